// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared SAP-1 types and default sizing constants
//
// Contents:
//   prog_state_t      - ram_programmer session states
//   SAP1_RAM_DEPTH    - default number of program RAM words
//   SAP1_WIDTH        - default RAM data width
//   sap1_is_active()  - true while a programming session owns the RAM
package sap1_pkg;

   localparam int SAP1_RAM_DEPTH = 16;
   localparam int SAP1_WIDTH     = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_DONE   = 2'd3
   } prog_state_t;

   // The CPU must be halted exactly while the programmer is loading or verifying.
   function automatic logic sap1_is_active(input prog_state_t s);
      return (s == ST_LOAD) || (s == ST_VERIFY);
   endfunction

endpackage

// File: rtl/ram_programmer.sv
// rtl/ram_programmer.sv - loads program RAM from a byte stream and verifies it by checksum
//
// Ports:
//   mclk          in   master clock
//   reset         in   asynchronous active-high reset
//   mclk_en       in   clock enable; state only advances on enabled edges
//   i_start       in   starts a session from IDLE or DONE
//   i_abort       in   ends an active session with an error
//   i_rx_valid    in   upstream byte valid
//   i_rx_data     in   upstream byte
//   o_rx_ready    out  byte accepted when valid, ready and mclk_en are high
//   o_address     out  RAM address
//   o_load_enable out  RAM write request (RAM qualifies it with mclk_en)
//   o_load_data   out  RAM write data
//   i_ram_data    in   combinational RAM read data at o_address
//   o_hold        out  CPU halt request while a session is active
//   o_done        out  session completed
//   o_error       out  last session failed its checksum or was aborted
module ram_programmer
   import sap1_pkg::*;
#(
   parameter  int RAM_DEPTH  = SAP1_RAM_DEPTH,
   parameter  int WIDTH      = SAP1_WIDTH,
   localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
   input  logic                  mclk,
   input  logic                  reset,
   input  logic                  mclk_en,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic                  i_rx_valid,
   input  logic [WIDTH-1:0]      i_rx_data,
   output logic                  o_rx_ready,
   output logic [ADDR_WIDTH-1:0] o_address,
   output logic                  o_load_enable,
   output logic [WIDTH-1:0]      o_load_data,
   input  logic [WIDTH-1:0]      i_ram_data,
   output logic                  o_hold,
   output logic                  o_done,
   output logic                  o_error
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   prog_state_t           state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      load_sum;
   logic [WIDTH-1:0]      verify_sum;
   logic                  done_q;
   logic                  error_q;

   logic                  in_load;
   logic                  at_last;
   logic [WIDTH-1:0]      verify_next;

   assign in_load     = (state == ST_LOAD);
   assign at_last     = (addr == LAST_ADDR);
   // Final verify compare includes the word being read this cycle.
   assign verify_next = verify_sum + i_ram_data;

   // Datapath outputs follow the stream combinationally while loading.
   // Abort wins over a coincident byte, so the write request is suppressed
   // in that cycle and the byte never reaches the RAM.
   assign o_rx_ready    = in_load;
   assign o_load_enable = in_load & i_rx_valid & ~i_abort;
   assign o_load_data   = in_load ? i_rx_data : '0;
   assign o_address     = (state == ST_IDLE) ? '0 : addr;
   assign o_hold        = sap1_is_active(state);
   assign o_done        = done_q;
   assign o_error       = error_q;

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         addr       <= '0;
         load_sum   <= '0;
         verify_sum <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else if (mclk_en) begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  state      <= ST_LOAD;
                  addr       <= '0;
                  load_sum   <= '0;
                  verify_sum <= '0;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
               end
            end

            ST_LOAD: begin
               if (i_abort) begin
                  state   <= ST_IDLE;
                  addr    <= '0;
                  done_q  <= 1'b0;
                  error_q <= 1'b1;
               end else if (i_rx_valid) begin
                  load_sum <= load_sum + i_rx_data;
                  if (at_last) begin
                     // Last word written: restart the counter for a single verify pass.
                     state      <= ST_VERIFY;
                     addr       <= '0;
                     verify_sum <= '0;
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end

            ST_VERIFY: begin
               if (i_abort) begin
                  state   <= ST_IDLE;
                  addr    <= '0;
                  done_q  <= 1'b0;
                  error_q <= 1'b1;
               end else if (at_last) begin
                  // Counter stays on the last address so DONE shows where verify ended.
                  state      <= ST_DONE;
                  verify_sum <= verify_next;
                  done_q     <= 1'b1;
                  error_q    <= (verify_next != load_sum);
               end else begin
                  verify_sum <= verify_next;
                  addr       <= addr + 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
